// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, the register-index address LSB,
// the read-channel state encoding and an index-width helper.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY         = 2'b00;
  localparam logic [1:0] RESP_SLVERR       = 2'b10;
  localparam int         AXI_LITE_ADDR_LSB = 2;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_e;

  function automatic int clog2(input int value);
    int result = 0;
    int v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axi_lite_regbank.sv
// Register bank: REG_NUM words with one byte-strobed write port, one
// combinational read port and a flat export of every word.
module axi_lite_regbank #(
  parameter int REG_NUM    = 16,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int IDX_W      = 4
) (
  input  logic                          aclk,
  input  logic                          arest,
  input  logic                          wr_en_i,
  input  logic [IDX_W-1:0]              wr_idx_i,
  input  logic [DATA_WIDTH-1:0]         wr_data_i,
  input  logic [STRB_WIDTH-1:0]         wr_strb_i,
  input  logic [IDX_W-1:0]              rd_idx_i,
  output logic [DATA_WIDTH-1:0]         rd_data_o,
  output logic [REG_NUM*DATA_WIDTH-1:0] reg_flat_o
);

  logic [DATA_WIDTH-1:0] regs_q [REG_NUM];

  // NOTE: this array is reset explicitly because every word is exported on
  // reg_flat_o; a plain RAM with no reset could not drive that port.
  always_ff @(posedge aclk) begin
    if (arest) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      for (int k = 0; k < STRB_WIDTH; k++) begin
        if (wr_strb_i[k]) begin
          regs_q[wr_idx_i][k*8 +: 8] <= wr_data_i[k*8 +: 8];
        end
      end
    end
  end

  assign rd_data_o = regs_q[rd_idx_i];

  for (genvar i = 0; i < REG_NUM; i++) begin : g_flat
    assign reg_flat_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

endmodule

// File: rtl/axi_lite_slave_regfile.sv
// AXI4-Lite slave terminating reads/writes into a register bank.
// Write channels and write logic exist only when AXI_LITE_SLV_WRITE_EN is defined.
module axi_lite_slave_regfile
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int PROT_WIDTH = 3,
  parameter int RESP_WIDTH = 2,
  parameter int REG_NUM    = 16
) (
  input  logic                          aclk,
  input  logic                          arest,
`ifdef AXI_LITE_SLV_WRITE_EN
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [ADDR_WIDTH-1:0]         s_axi_awaddr,
  input  logic [PROT_WIDTH-1:0]         s_axi_awprot,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  input  logic [DATA_WIDTH-1:0]         s_axi_wdata,
  input  logic [STRB_WIDTH-1:0]         s_axi_wstrb,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  output logic [RESP_WIDTH-1:0]         s_axi_bresp,
`endif
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  input  logic [ADDR_WIDTH-1:0]         s_axi_araddr,
  input  logic [PROT_WIDTH-1:0]         s_axi_arprot,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic [DATA_WIDTH-1:0]         s_axi_rdata,
  output logic [RESP_WIDTH-1:0]         s_axi_rresp,
  output logic [REG_NUM*DATA_WIDTH-1:0] reg_flat
);

  localparam int IDX_W     = clog2(REG_NUM);
  localparam int RANGE_LSB = AXI_LITE_ADDR_LSB + IDX_W;

  logic                  ready_q;
  logic                  we;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic [DATA_WIDTH-1:0] rd_data;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of its neighbours, whatever the evaluation order.
  always_ff @(posedge aclk) begin
    if (arest) ready_q <= 1'b0;
    else       ready_q <= 1'b1;
  end

  // ---------------- read channel ----------------
  rd_state_e             rd_state_q, rd_state_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [RESP_WIDTH-1:0] rresp_q, rresp_d;
  logic                  ar_hs;
  logic                  ar_in_range;
  logic                  unused_rd;

  assign s_axi_arready = ready_q & (rd_state_q == RD_IDLE);
  assign s_axi_rvalid  = (rd_state_q == RD_RESP);
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign ar_hs         = s_axi_arvalid & s_axi_arready;
  assign ar_in_range   = (s_axi_araddr >> RANGE_LSB) == '0;
  assign unused_rd     = ^s_axi_arprot;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (ar_hs) begin
          rd_state_d = RD_RESP;
          rdata_d    = ar_in_range ? rd_data : '0;
          rresp_d    = ar_in_range ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_SLVERR);
        end
      end
      RD_RESP: begin
        if (s_axi_rready) rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (arest) begin
      rd_state_q <= RD_IDLE;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

`ifdef AXI_LITE_SLV_WRITE_EN
  // ---------------- write channels ----------------
  logic                  aw_full_q, aw_full_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                  w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [RESP_WIDTH-1:0] bresp_q, bresp_d;
  logic                  aw_hs, w_hs, commit, wr_in_range;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  unused_wr;

  assign s_axi_awready = ready_q & ~aw_full_q & ~bvalid_q;
  assign s_axi_wready  = ready_q & ~w_full_q & ~bvalid_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign aw_hs         = s_axi_awvalid & s_axi_awready;
  assign w_hs          = s_axi_wvalid & s_axi_wready;
  assign unused_wr     = ^s_axi_awprot;

  // A held buffer takes precedence; otherwise the beat handshaking this cycle is used.
  assign wr_addr     = aw_full_q ? awaddr_q : s_axi_awaddr;
  assign wr_data     = w_full_q ? wdata_q : s_axi_wdata;
  assign wr_strb     = w_full_q ? wstrb_q : s_axi_wstrb;
  assign wr_in_range = (wr_addr >> RANGE_LSB) == '0;
  assign commit      = (aw_full_q | aw_hs) & (w_full_q | w_hs) & ~bvalid_q;
  assign we          = commit & wr_in_range;
  assign wr_idx      = wr_addr[AXI_LITE_ADDR_LSB +: IDX_W];

  always_comb begin
    aw_full_d = aw_full_q;
    awaddr_d  = awaddr_q;
    w_full_d  = w_full_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_in_range ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_SLVERR);
    end else begin
      if (aw_hs) begin
        aw_full_d = 1'b1;
        awaddr_d  = s_axi_awaddr;
      end
      if (w_hs) begin
        w_full_d = 1'b1;
        wdata_d  = s_axi_wdata;
        wstrb_d  = s_axi_wstrb;
      end
      if (bvalid_q && s_axi_bready) bvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (arest) begin
      aw_full_q <= 1'b0;
      awaddr_q  <= '0;
      w_full_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      awaddr_q  <= awaddr_d;
      w_full_q  <= w_full_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end
`else
  // Read-only build: the bank never sees a write, so every word stays at zero.
  assign we      = 1'b0;
  assign wr_idx  = '0;
  assign wr_data = '0;
  assign wr_strb = '0;
`endif

  axi_lite_regbank #(
    .REG_NUM    (REG_NUM),
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH),
    .IDX_W      (IDX_W)
  ) u_regbank (
    .aclk       (aclk),
    .arest      (arest),
    .wr_en_i    (we),
    .wr_idx_i   (wr_idx),
    .wr_data_i  (wr_data),
    .wr_strb_i  (wr_strb),
    .rd_idx_i   (s_axi_araddr[AXI_LITE_ADDR_LSB +: IDX_W]),
    .rd_data_o  (rd_data),
    .reg_flat_o (reg_flat)
  );

endmodule
